// File: rtl/fifo_pkg.sv
// Shared definitions for the asynchronous FIFO: default geometry, pointer type
// and Gray-code conversions used on both clock domains.
package fifo_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_ADDR_WIDTH = 5;
  localparam int unsigned PTR_WIDTH      = DEF_ADDR_WIDTH + 1;

  typedef logic [PTR_WIDTH-1:0] ptr_t;

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above its position.
  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b = '0;
    for (int i = 0; i < int'(PTR_WIDTH); i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// Read-side port of the asynchronous FIFO: consumer handshake, storage read
// path and the Gray pointers exchanged with the write domain.
interface fifo_rd_ctrl_if #(
  parameter int unsigned DATA_WIDTH = fifo_pkg::DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = fifo_pkg::DEF_ADDR_WIDTH
);

  logic                  read_enable;
  logic [ADDR_WIDTH-1:0] aempty_value;
  logic [ADDR_WIDTH:0]   wptr_gray;
  logic [ADDR_WIDTH:0]   rptr_gray;
  logic [ADDR_WIDTH-1:0] mem_raddr;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  rdempty;
  logic                  rd_almost_empty;
  logic                  underflow;
  logic [ADDR_WIDTH:0]   fifo_read_count;
  logic [ADDR_WIDTH:0]   rd_level;

  // Consumer / environment side.
  modport master (
    output read_enable, aempty_value, wptr_gray, mem_rdata,
    input  rptr_gray, mem_raddr, read_data, rdempty, rd_almost_empty,
           underflow, fifo_read_count, rd_level
  );

  // Read controller side.
  modport slave (
    input  read_enable, aempty_value, wptr_gray, mem_rdata,
    output rptr_gray, mem_raddr, read_data, rdempty, rd_almost_empty,
           underflow, fifo_read_count, rd_level
  );

endinterface

// File: rtl/ptr_sync_2ff.sv
// Two-flop synchronizer for a Gray-coded pointer crossing into this clock
// domain; clr gives a synchronous clear alongside the asynchronous reset.
module ptr_sync_2ff #(
  parameter int unsigned WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else if (clr) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-domain controller of the asynchronous FIFO: synchronizes the write
// pointer, advances the read pointer and produces registered data and status.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input logic           rclk,
  input logic           hw_rst,
  input logic           sw_rst,
  fifo_rd_ctrl_if.slave bus
);

  localparam int unsigned PW = ADDR_WIDTH + 1;

  logic [PW-1:0]         wq2;
  logic [PW-1:0]         wbin_s;
  logic [PW-1:0]         rbin_q;
  logic [PW-1:0]         rbin_next;
  logic [PW-1:0]         rgray_q;
  logic [PW-1:0]         rgray_next;
  logic [PW-1:0]         level_next;
  logic [PW-1:0]         level_q;
  logic [PW-1:0]         count_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  empty_q;
  logic                  aempty_q;
  logic                  uflow_q;
  logic                  rd_ok;

  ptr_sync_2ff #(
    .WIDTH (PW)
  ) u_wptr_sync (
    .clk (rclk),
    .rst (hw_rst),
    .clr (sw_rst),
    .d   (bus.wptr_gray),
    .q   (wq2)
  );

  // Gray to binary without a bit-serial chain: each bit is a prefix XOR.
  always_comb begin
    wbin_s = '0;
    for (int i = 0; i < int'(PW); i++) begin
      wbin_s[i] = ^(wq2 >> i);
    end
  end

  assign rd_ok      = bus.read_enable & ~empty_q;
  assign rbin_next  = rbin_q + PW'(rd_ok);
  assign rgray_next = rbin_next ^ (rbin_next >> 1);
  assign level_next = wbin_s - rbin_next;

  always_ff @(posedge rclk or posedge hw_rst) begin
    if (hw_rst) begin
      rbin_q   <= '0;
      rgray_q  <= '0;
      count_q  <= '0;
      data_q   <= '0;
      level_q  <= '0;
      empty_q  <= 1'b1;
      aempty_q <= 1'b1;
      uflow_q  <= 1'b0;
    end else if (sw_rst) begin
      rbin_q   <= '0;
      rgray_q  <= '0;
      count_q  <= '0;
      data_q   <= '0;
      level_q  <= '0;
      empty_q  <= 1'b1;
      aempty_q <= 1'b1;
      uflow_q  <= 1'b0;
    end else begin
      rbin_q   <= rbin_next;
      rgray_q  <= rgray_next;
      empty_q  <= (rgray_next == wq2);
      level_q  <= level_next;
      aempty_q <= (level_next <= PW'(bus.aempty_value));
      uflow_q  <= bus.read_enable & empty_q;
      if (rd_ok) begin
        data_q  <= bus.mem_rdata;
        count_q <= count_q + PW'(1);
      end
    end
  end

  assign bus.rptr_gray       = rgray_q;
  assign bus.mem_raddr       = rbin_q[ADDR_WIDTH-1:0];
  assign bus.read_data       = data_q;
  assign bus.rdempty         = empty_q;
  assign bus.rd_almost_empty = aempty_q;
  assign bus.underflow       = uflow_q;
  assign bus.fifo_read_count = count_q;
  assign bus.rd_level        = level_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Scoreboard bench for fifo_rd_ctrl: a word-queue model predicts every edge,
// a monitor compares the DUT outputs one time unit after each rising edge.
module tb_fifo_rd_ctrl;
  import fifo_pkg::*;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned DEPTH = 32;

  typedef struct {
    logic [DW-1:0] data;
    logic          empty;
    logic          aempty;
    logic          uflow;
    logic [AW:0]   level;
    logic [AW:0]   count;
    logic [AW:0]   gray;
    logic [AW-1:0] raddr;
    int            toggles;
  } exp_t;

  logic rclk = 1'b0;
  logic hw_rst;
  logic sw_rst;

  always #5 rclk = ~rclk;

  fifo_rd_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  logic [DW-1:0] mem [DEPTH];
  assign bus.mem_rdata = mem[bus.mem_raddr];

  fifo_rd_ctrl #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .rclk   (rclk),
    .hw_rst (hw_rst),
    .sw_rst (sw_rst),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  exp_t          exp_q [$];
  logic [DW-1:0] words [$];
  logic [DW-1:0] wr_src [$];
  int            wr_total;
  int            rd_total;
  int            seen1;
  int            seen2;
  logic [DW-1:0] m_data;
  logic          m_empty;
  logic [AW:0]   m_count;
  logic [AW-1:0] cur_aev;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, req);
  endtask

  // One clock cycle: drive inputs at the falling edge and queue the expected
  // state after the following rising edge.
  task automatic cycle(input bit re, input bit srst, input bit hrst, input int nwr);
    exp_t          e;
    int            level;
    bit            ok;
    logic [DW-1:0] d;
    @(negedge rclk);
    bus.read_enable  = re;
    bus.aempty_value = cur_aev;
    sw_rst           = srst;
    if (hrst && !hw_rst) begin
      hw_rst = 1'b1;
      #1;
      chk("async_rdempty", 64'(bus.rdempty), 64'd1);
      chk("async_read_data", 64'(bus.read_data), 64'd0);
      chk("async_read_count", 64'(bus.fifo_read_count), 64'd0);
      chk("async_rd_level", 64'(bus.rd_level), 64'd0);
    end
    hw_rst = hrst;
    if (srst || hrst) begin
      wr_total = 0;
      rd_total = 0;
      seen1    = 0;
      seen2    = 0;
      words.delete();
      m_data  = '0;
      m_empty = 1'b1;
      m_count = '0;
      bus.wptr_gray = '0;
      e = '{data: '0, empty: 1'b1, aempty: 1'b1, uflow: 1'b0, level: '0,
            count: '0, gray: '0, raddr: '0, toggles: -1};
    end else begin
      for (int i = 0; i < nwr; i++) begin
        if (wr_total - rd_total < int'(DEPTH)) begin
          d = (wr_src.size() > 0) ? wr_src.pop_front() : DW'($urandom);
          mem[AW'(wr_total)] = d;
          words.push_back(d);
          wr_total++;
        end
      end
      bus.wptr_gray = bin2gray(ptr_t'(wr_total));
      ok      = re && !m_empty;
      e.uflow = re && m_empty;
      if (ok) begin
        m_data = words.pop_front();
        rd_total++;
        m_count = m_count + 1'b1;
      end
      // Writes become visible to the read side two edges after they are sampled.
      level    = seen2 - rd_total;
      m_empty  = (level == 0);
      e.data   = m_data;
      e.empty  = m_empty;
      e.aempty = (level <= int'(cur_aev));
      e.level  = (AW + 1)'(level);
      e.count  = m_count;
      e.gray   = bin2gray(ptr_t'(rd_total));
      e.raddr  = AW'(rd_total);
      e.toggles = ok ? 1 : 0;
      seen2 = seen1;
      seen1 = wr_total;
    end
    exp_q.push_back(e);
  endtask

  exp_t        mon_e;
  logic [AW:0] prev_gray = '0;

  always @(posedge rclk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("rdempty", 64'(bus.rdempty), 64'(mon_e.empty));
      chk("rd_almost_empty", 64'(bus.rd_almost_empty), 64'(mon_e.aempty));
      chk("underflow", 64'(bus.underflow), 64'(mon_e.uflow));
      chk("rd_level", 64'(bus.rd_level), 64'(mon_e.level));
      chk("read_data", 64'(bus.read_data), 64'(mon_e.data));
      chk("fifo_read_count", 64'(bus.fifo_read_count), 64'(mon_e.count));
      chk("rptr_gray", 64'(bus.rptr_gray), 64'(mon_e.gray));
      chk("mem_raddr", 64'(bus.mem_raddr), 64'(mon_e.raddr));
      if (mon_e.toggles >= 0) begin
        chk("rptr_gray_bits_changed", 64'($countones(bus.rptr_gray ^ prev_gray)),
            64'(mon_e.toggles));
      end
      prev_gray = bus.rptr_gray;
    end
  end

  initial begin
    hw_rst           = 1'b1;
    sw_rst           = 1'b0;
    bus.read_enable  = 1'b0;
    bus.aempty_value = '0;
    bus.wptr_gray    = '0;
    cur_aev          = AW'(2);
    wr_total = 0;
    rd_total = 0;
    seen1    = 0;
    seen2    = 0;
    m_data   = '0;
    m_empty  = 1'b1;
    m_count  = '0;
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = '0;

    // Reset held for three cycles, then released.
    repeat (3) cycle(1'b0, 1'b0, 1'b1, 0);
    cycle(1'b0, 1'b0, 1'b0, 0);

    // Pointer step to Gray(4) and synchronizer latency, then drain A0..A3.
    wr_src = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    cycle(1'b0, 1'b0, 1'b0, 4);
    repeat (4) cycle(1'b0, 1'b0, 1'b0, 0);
    repeat (4) cycle(1'b1, 1'b0, 1'b0, 0);

    // Rejected reads on an empty FIFO.
    repeat (2) cycle(1'b1, 1'b0, 1'b0, 0);
    cycle(1'b0, 1'b0, 1'b0, 0);

    // Fill to 32 words, then drain past empty.
    cur_aev = AW'(31);
    repeat (32) cycle(1'b0, 1'b0, 1'b0, 1);
    repeat (4) cycle(1'b0, 1'b0, 1'b0, 0);
    repeat (34) cycle(1'b1, 1'b0, 1'b0, 0);

    // Soft reset colliding with a read at level 10.
    cur_aev = AW'(0);
    repeat (12) cycle(1'b0, 1'b0, 1'b0, 1);
    repeat (4) cycle(1'b0, 1'b0, 1'b0, 0);
    repeat (2) cycle(1'b1, 1'b0, 1'b0, 0);
    cycle(1'b1, 1'b1, 1'b0, 0);
    cycle(1'b0, 1'b0, 1'b0, 0);

    // 62 reads, then four more so the read pointer wraps 63 -> 0.
    cur_aev = AW'(3);
    repeat (2) begin
      repeat (31) cycle(1'b0, 1'b0, 1'b0, 1);
      repeat (4) cycle(1'b0, 1'b0, 1'b0, 0);
      repeat (31) cycle(1'b1, 1'b0, 1'b0, 0);
    end
    repeat (4) cycle(1'b0, 1'b0, 1'b0, 1);
    repeat (4) cycle(1'b0, 1'b0, 1'b0, 0);
    repeat (5) cycle(1'b1, 1'b0, 1'b0, 0);

    // Hard reset arriving in the middle of a read burst.
    repeat (6) cycle(1'b0, 1'b0, 1'b0, 1);
    repeat (4) cycle(1'b0, 1'b0, 1'b0, 0);
    repeat (2) cycle(1'b1, 1'b0, 1'b0, 0);
    cycle(1'b1, 1'b0, 1'b1, 0);
    cycle(1'b0, 1'b0, 1'b0, 0);

    // Random traffic with occasional resets and threshold changes.
    for (int c = 0; c < 800; c++) begin
      if (c % 50 == 0) cur_aev = AW'($urandom);
      cycle($urandom_range(3, 0) != 0, $urandom_range(299, 0) == 0,
            $urandom_range(399, 0) == 0, int'($urandom_range(2, 0)));
    end
    cycle(1'b0, 1'b0, 1'b0, 0);

    repeat (3) @(negedge rclk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
